pau_issue_ctrl: RTL and testbench

PAU_ISSUE_CTRL -- requirements
Module: pau_issue_ctrl

---
 rtl/pau_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_pau_issue_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pau_issue_ctrl.sv
// Issue/retire controller for a posit arithmetic unit.
// Fixed per-class latency, slot-shifted retirement, one retire per cycle.
module pau_issue_ctrl #(
    parameter int TRANS_ID_BITS = 3,
    parameter int LAT_ADD       = 3,
    parameter int LAT_MUL       = 2,
    parameter int LAT_DIV       = 4,
    parameter int LAT_CVT       = 2,
    parameter int LAT_MOVE      = 1,
    parameter int LAT_QUIRE     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  logic [2:0]               op_class_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic                     flush_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [2:0]               class_o,
    output logic                     illegal_o,
    output logic                     busy_o,
    output logic [3:0]               inflight_o
);

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_LAT = max2(max2(max2(LAT_ADD, LAT_MUL), max2(LAT_DIV, LAT_CVT)),
                                  max2(LAT_MOVE, LAT_QUIRE));
    localparam int W = TRANS_ID_BITS;

    // Slot 0 is the retirement stage that feeds the outputs directly.
    logic [MAX_LAT-1:0]         v_q, v_d;
    logic [MAX_LAT-1:0]         ill_q, ill_d;
    logic [MAX_LAT-1:0][W-1:0]  id_q, id_d;
    logic [MAX_LAT-1:0][2:0]    cls_q, cls_d;
    logic [3:0]                 cnt_q, cnt_d;

    logic [3:0] lat;
    logic       collide;
    logic       q_haz;
    logic       acc;

    // Latency of the presented class; illegal classes retire after one edge.
    always_comb begin
        lat = 4'd1;
        case (op_class_i)
            3'd0:    lat = 4'(LAT_ADD);
            3'd1:    lat = 4'(LAT_MUL);
            3'd2:    lat = 4'(LAT_DIV);
            3'd3:    lat = 4'(LAT_CVT);
            3'd4:    lat = 4'(LAT_MOVE);
            3'd5:    lat = 4'(LAT_QUIRE);
            default: lat = 4'd1;
        endcase
    end

    // Retire-slot collision and quire hazard; a quire in slot 1 leaves this edge.
    always_comb begin
        collide = 1'b0;
        q_haz   = 1'b0;
        for (int i = 1; i < MAX_LAT; i++) begin
            if (v_q[i] && int'(lat) == i) collide = 1'b1;
        end
        for (int i = 2; i < MAX_LAT; i++) begin
            if (v_q[i] && cls_q[i] == 3'd5) q_haz = 1'b1;
        end
    end

    assign ready_o = !flush_i && !collide && !(op_class_i == 3'd5 && q_haz);
    assign acc     = valid_i && ready_o;

    // Shift slots toward retirement and drop the new op into slot lat-1.
    always_comb begin
        v_d   = v_q >> 1;
        ill_d = ill_q >> 1;
        id_d  = id_q >> W;
        cls_d = cls_q >> 3;
        cnt_d = cnt_q + {3'b0, acc} - {3'b0, v_q[0]};
        for (int i = 0; i < MAX_LAT; i++) begin
            if (acc && int'(lat) == i + 1) begin
                v_d[i]   = 1'b1;
                ill_d[i] = (op_class_i > 3'd5);
                id_d[i]  = trans_id_i;
                cls_d[i] = op_class_i;
            end
        end
        if (flush_i) begin
            v_d   = '0;
            ill_d = '0;
            id_d  = '0;
            cls_d = '0;
            cnt_d = 4'd0;
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            ill_q <= '0;
            id_q  <= '0;
            cls_q <= '0;
            cnt_q <= 4'd0;
        end else begin
            v_q   <= v_d;
            ill_q <= ill_d;
            id_q  <= id_d;
            cls_q <= cls_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o    = v_q[0];
    assign trans_id_o = v_q[0] ? id_q[0] : '0;
    assign class_o    = v_q[0] ? cls_q[0] : 3'd0;
    assign illegal_o  = v_q[0] & ill_q[0];
    assign busy_o     = (cnt_q != 4'd0);
    assign inflight_o = cnt_q;

endmodule

// File: tb/tb_pau_issue_ctrl.sv
// Testbench for pau_issue_ctrl: directed vector table, reset corner,
// and randomized traffic against a retire-time reference model.
module tb_pau_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] cls = 3'd0;
    logic [2:0] id = 3'd0;
    logic       flush = 1'b0;
    logic       ready_o, valid_o, illegal_o, busy_o;
    logic [2:0] trans_id_o, class_o;
    logic [3:0] inflight_o;

    pau_issue_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid),
        .op_class_i (cls),
        .trans_id_i (id),
        .flush_i    (flush),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .trans_id_o (trans_id_o),
        .class_o    (class_o),
        .illegal_o  (illegal_o),
        .busy_o     (busy_o),
        .inflight_o (inflight_o)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int e = 0;

    typedef struct {
        int id;
        int c;
        int re;
    } ent_t;
    ent_t q[$];

    typedef struct {
        bit v; int c; int i; bit fl;
        int rdy; int vo; int id; int cl; int il; int infl;
    } vec_t;
    vec_t vt[$];

    int a_rdy, a_vo, a_id, a_cl, a_il, a_infl;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, e);
        end
    endtask

    function automatic int lat_of(input int c);
        case (c)
            0: return 3;
            1: return 2;
            2: return 4;
            3: return 2;
            4: return 1;
            5: return 2;
            default: return 1;
        endcase
    endfunction

    // Ready: no op already retiring at the same edge, no quire still
    // in flight past the coming edge, and no flush.
    function automatic int mdl_rdy(input int c, input bit fl);
        int tgt;
        if (fl) return 0;
        tgt = e + lat_of(c) - 1;
        foreach (q[k]) begin
            if (q[k].re == tgt) return 0;
            if (c == 5 && q[k].c == 5 && q[k].re > e) return 0;
        end
        return 1;
    endfunction

    task automatic cyc(input bit v, input int c, input int i, input bit fl);
        int m_rdy, ev, eid, ecl, eil, n;
        valid = v;
        cls = c[2:0];
        id = i[2:0];
        flush = fl;
        #1;
        m_rdy = mdl_rdy(c, fl);
        a_rdy = int'(ready_o);
        chk("ready", a_rdy, m_rdy);
        @(posedge clk);
        if (fl) q.delete();
        else if (v && m_rdy != 0) q.push_back('{i, c, e + lat_of(c) - 1});
        ev = 0; eid = 0; ecl = 0; eil = 0; n = 0;
        foreach (q[k]) begin
            if (q[k].re == e) begin
                ev = 1; eid = q[k].id; ecl = q[k].c; eil = (q[k].c > 5) ? 1 : 0;
            end
            if (q[k].re >= e) n++;
        end
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].re < e) q.delete(k);
        end
        e++;
        #1;
        a_vo = int'(valid_o);
        a_id = int'(trans_id_o);
        a_cl = int'(class_o);
        a_il = int'(illegal_o);
        a_infl = int'(inflight_o);
        chk("valid_o", a_vo, ev);
        chk("trans_id_o", a_id, eid);
        chk("class_o", a_cl, ecl);
        chk("illegal_o", a_il, eil);
        chk("inflight_o", a_infl, n);
        chk("busy_o", int'(busy_o), (n != 0) ? 1 : 0);
    endtask

    task automatic add(input bit v, input int c, input int i, input bit fl,
                       input int rdy, input int vo, input int tid,
                       input int cl, input int il, input int infl);
        vt.push_back('{v, c, i, fl, rdy, vo, tid, cl, il, infl});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, int'(valid_o), 0);
        chk({nm, "_id"}, int'(trans_id_o), 0);
        chk({nm, "_class"}, int'(class_o), 0);
        chk({nm, "_illegal"}, int'(illegal_o), 0);
        chk({nm, "_busy"}, int'(busy_o), 0);
        chk({nm, "_inflight"}, int'(inflight_o), 0);
    endtask

    initial begin
        // ADD id5: retires after third edge
        add(1, 0, 5, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 5, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // ADD id1 then MUL id2 collides once
        add(1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 2, 0, 1, 1, 1, 0, 0, 2);
        add(0, 0, 0, 0, 1, 1, 2, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // back-to-back QUIRE, second accepted as first retires
        add(1, 5, 2, 0, 1, 0, 0, 0, 0, 1);
        add(1, 5, 3, 0, 1, 1, 2, 5, 0, 2);
        add(0, 0, 0, 0, 1, 1, 3, 5, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // DIV flushed
        add(1, 2, 4, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // illegal class 7
        add(1, 7, 6, 0, 1, 1, 6, 7, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // MOVE stream
        for (int k = 0; k < 8; k++) add(1, 4, k, 0, 1, 1, k, 4, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        #2;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int r = 0; r < vt.size(); r++) begin
            cyc(vt[r].v, vt[r].c, vt[r].i, vt[r].fl);
            chk($sformatf("t%0d_rdy", r), a_rdy, vt[r].rdy);
            chk($sformatf("t%0d_vo", r), a_vo, vt[r].vo);
            chk($sformatf("t%0d_id", r), a_id, vt[r].id);
            chk($sformatf("t%0d_cls", r), a_cl, vt[r].cl);
            chk($sformatf("t%0d_ill", r), a_il, vt[r].il);
            chk($sformatf("t%0d_infl", r), a_infl, vt[r].infl);
        end

        // reset while ADD id1 is in flight
        cyc(1, 0, 1, 0);
        cyc(0, 4, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        valid = 1'b0;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_zero("postrst");
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
